// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an 8N1/8N2 UART transmitter.
// Bytes enter on a data_en strobe, wait in a small FIFO and go out
// LSB first on tx. busy is high while the FIFO is full; a strobe seen while
// busy is high is ignored.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit(s), which gives 8E1/8E2 frames.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_en,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    // FIFO storage and control
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             busy_q;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    // Transmitter state
    state_t           state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             baud_last;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
`endif

    assign push      = data_en && !busy_q;
    assign head      = mem_q[rd_ptr_q];
    assign baud_last = (baud_q == BAUD_LAST);
    assign busy      = busy_q;
    assign tx        = tx_q;

    // Pop the head when idle, or on the final stop cycle so frames run back to back.
    always_comb begin
        pop = 1'b0;
        if (count_q != '0) begin
            if (state_q == S_IDLE) begin
                pop = 1'b1;
            end else if (state_q == S_STOP && baud_last && bit_cnt_q == STOP_LAST) begin
                pop = 1'b1;
            end
        end
    end

    // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Byte storage: written at the tail on an accepted strobe, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // FIFO pointers, count and the registered full flag; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            busy_q  <= (count_d == DEPTH_C);
        end
    end

    // Shift register: loaded on pop, shifted right as each data bit completes.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_q <= head;
        end else if (state_q == S_DATA && baud_last) begin
            shift_q <= shift_q >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte being sent, captured when it leaves the FIFO.
    always_ff @(posedge clk) begin
        if (pop) begin
            par_q <= ^head;
        end
    end
`endif

    // Frame sequencer; tx is registered and updated on the edge that enters each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q      <= 1'b1;
                    baud_q    <= '0;
                    bit_cnt_q <= '0;
                    if (pop) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= S_PARITY;
                            tx_q      <= par_q;
`else
                            state_q   <= S_STOP;
                            tx_q      <= 1'b1;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_STOP;
                        tx_q      <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_q <= '0;
                            if (pop) begin
                                state_q <= S_START;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    baud_q    <= '0;
                    bit_cnt_q <= '0;
                    tx_q      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=8, FIFO_DEPTH=4, one stop bit.
// Define UART_TX_PARITY_EN for both files to exercise the parity frames.
module tb_uart_tx_fifo;

    localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       data_en;
    logic [7:0] data_in;
    logic       busy;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seq3 [3] = '{8'h55, 8'hAA, 8'h00};
    logic [7:0] seq6 [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0] seq5r [3] = '{8'hF0, 8'h11, 8'h22};

    uart_tx_fifo #(
        .CLK_FREQ  (8),
        .BAUD      (1),
        .FIFO_DEPTH(4),
        .STOP_BITS (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_en(data_en),
        .data_in(data_in),
        .busy   (busy),
        .tx     (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called on a negedge; waits for the start bit then checks every cycle of the frame.
    task automatic rx_frame(input string tag, input logic [7:0] exp, input int exp_wait);
        int waited;
        int errs;
        int b;
        logic [7:0] got;
        waited = 0;
        errs   = 0;
        got    = '0;
        @(negedge clk);
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, "_wait"}, waited, exp_wait);
        if (tx !== 1'b0) return;
        for (int i = 0; i < NBITS * CPB; i++) begin
            if (i > 0) @(negedge clk);
            b = i / CPB;
            if (b >= 1 && b <= 8 && (i % CPB) == 0) got[b-1] = tx;
            if (tx !== frame_bit(exp, b)) errs++;
        end
        check_val({tag, "_byte"}, got, exp);
        check_val({tag, "_bits"}, errs, 0);
    endtask

    task automatic idle_check(input string tag, input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) errs++;
        end
        check_val(tag, errs, 0);
    endtask

    initial begin
        rst     = 1'b1;
        data_en = 1'b0;
        data_in = 8'h00;

        // 1. reset state and idle line
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_tx", tx, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle_check("idle_100", 100);
        check_val("idle_busy", busy, 1'b0);

        // 2. single byte 0x41
        fork
            begin
                data_en = 1'b1;
                data_in = 8'h41;
                @(negedge clk);
                data_en = 1'b0;
            end
            rx_frame("single41", 8'h41, 1);
        join
        idle_check("single_after", 20);

        // 3. back-to-back frames in order
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    data_en = 1'b1;
                    data_in = seq3[k];
                    @(negedge clk);
                end
                data_en = 1'b0;
            end
            begin
                rx_frame("b2b_55", 8'h55, 1);
                rx_frame("b2b_aa", 8'hAA, 0);
                rx_frame("b2b_00", 8'h00, 0);
            end
        join
        idle_check("b2b_after", 20);

        // 4. fill the FIFO, drop the sixth byte
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    if (k == 4) check_val("full_busy_3q", busy, 1'b0);
                    if (k == 5) check_val("full_busy_4q", busy, 1'b1);
                    data_en = 1'b1;
                    data_in = seq6[k];
                    @(negedge clk);
                end
                data_en = 1'b0;
                check_val("full_busy_drop", busy, 1'b1);
            end
            begin
                rx_frame("full_01", 8'h01, 1);
                rx_frame("full_02", 8'h02, 0);
                rx_frame("full_03", 8'h03, 0);
                rx_frame("full_04", 8'h04, 0);
                rx_frame("full_05", 8'h05, 0);
            end
        join
        idle_check("full_no06", 200);
        check_val("full_busy_end", busy, 1'b0);

        // 5. reset during data bit 3 of 0xF0 with two bytes queued
        for (int k = 0; k < 3; k++) begin
            data_en = 1'b1;
            data_in = seq5r[k];
            @(negedge clk);
        end
        data_en = 1'b0;
        repeat (33) @(negedge clk);
        check_val("midrst_bit3", tx, 1'b0);
        check_val("midrst_busy_pre", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_tx", tx, 1'b1);
        check_val("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        idle_check("midrst_silent", 300);

`ifdef UART_TX_PARITY_EN
        // 6. parity frames, 88 cycles each
        fork
            begin
                data_en = 1'b1;
                data_in = 8'h41;
                @(negedge clk);
                data_en = 1'b0;
            end
            rx_frame("par_41", 8'h41, 1);
        join
        idle_check("par_41_after", 10);
        fork
            begin
                data_en = 1'b1;
                data_in = 8'h07;
                @(negedge clk);
                data_en = 1'b0;
            end
            rx_frame("par_07", 8'h07, 1);
        join
        idle_check("par_07_after", 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
